// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register-file reads for one decoded instruction, resolves
// operands after the one-cycle RAM latency with writeback forwarding, hands off via valid/ready.
module operand_fetch #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  output logic              new_instr,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2
);

  typedef enum logic [1:0] {StIdle, StRead, StValid} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic              fwd1_q, fwd1_d;
  logic              fwd2_q, fwd2_d;
  logic [XLEN-1:0]   fwd1_data_q, fwd1_data_d;
  logic [XLEN-1:0]   fwd2_data_q, fwd2_data_d;

  logic              accept;
  logic [REG_AW-1:0] rs1_in, rs2_in, rs1_held, rs2_held;
  logic              hit1_in, hit2_in, hit1_held, hit2_held;

  assign rs1_in   = in_instr[15 +: REG_AW];
  assign rs2_in   = in_instr[20 +: REG_AW];
  assign rs1_held = instr_q[15 +: REG_AW];
  assign rs2_held = instr_q[20 +: REG_AW];

  // x0 never forwards, even on a write addressed to x0.
  assign hit1_in   = wb_we && (wb_wa == rs1_in)   && (rs1_in   != '0);
  assign hit2_in   = wb_we && (wb_wa == rs2_in)   && (rs2_in   != '0);
  assign hit1_held = wb_we && (wb_wa == rs1_held) && (rs1_held != '0);
  assign hit2_held = wb_we && (wb_wa == rs2_held) && (rs2_held != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      fwd1_data_q <= fwd1_data_d;
      fwd2_data_q <= fwd2_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept) state_d = StRead;
        StRead:  state_d = StValid;
        StValid: if (out_ready) state_d = accept ? StRead : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StValid) && out_ready);
    accept    = in_valid && in_ready && !flush;
    new_instr = accept;
    ra1       = in_ready ? rs1_in : rs1_held;
    ra2       = in_ready ? rs2_in : rs2_held;
    out_valid = (state_q == StValid);
    out_instr = instr_q;
    out_op1   = op1_q;
    out_op2   = op2_q;
  end

  // The RAM returns pre-write data on a same-edge collision, so a writeback seen in the
  // accept cycle is latched and one seen in the read cycle is taken directly.
  always_comb begin
    instr_d     = instr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    fwd1_d      = fwd1_q;
    fwd2_d      = fwd2_q;
    fwd1_data_d = fwd1_data_q;
    fwd2_data_d = fwd2_data_q;
    if (flush) begin
      fwd1_d = 1'b0;
      fwd2_d = 1'b0;
    end else if (accept) begin
      instr_d     = in_instr;
      fwd1_d      = hit1_in;
      fwd2_d      = hit2_in;
      fwd1_data_d = wb_wd;
      fwd2_data_d = wb_wd;
    end else if (state_q == StRead) begin
      if (rs1_held == '0)  op1_d = '0;
      else if (hit1_held)  op1_d = wb_wd;
      else if (fwd1_q)     op1_d = fwd1_data_q;
      else                 op1_d = rd1;
      if (rs2_held == '0)  op2_d = '0;
      else if (hit2_held)  op2_d = wb_wd;
      else if (fwd2_q)     op2_d = fwd2_data_q;
      else                 op2_d = rd2;
    end else if ((state_q == StValid) && !out_ready) begin
      if (hit1_held) op1_d = wb_wd;
      if (hit2_held) op2_d = wb_wd;
    end
  end

endmodule
